// File: rtl/disp_pkg.sv
// Shared constants and slot typedef for the BCD heading 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_DEG  = 7'h63;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef enum logic [1:0] {
        SLOT_ONES = 2'd0,
        SLOT_TENS = 2'd1,
        SLOT_HUND = 2'd2,
        SLOT_DEG  = 2'd3
    } slot_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Latches a 3-digit BCD heading and scans it onto a 4-digit common-anode display.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module bcd_seg7_scanner
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hund,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned     CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] r_cnt;
    slot_e            r_idx;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic [3:0]       r_hund;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_frame_tick;

    logic             w_slot_end;
    logic [3:0]       w_nib;
    logic [6:0]       w_dec;
    logic [6:0]       w_slot_seg;
    logic             w_lzb;
    logic             w_dark;

    assign w_slot_end = (r_cnt == CNT_MAX);

    always_comb begin
        w_nib = r_ones;
        unique case (r_idx)
            SLOT_ONES: w_nib = r_ones;
            SLOT_TENS: w_nib = r_tens;
            SLOT_HUND: w_nib = r_hund;
            SLOT_DEG:  w_nib = r_ones;
            default:   w_nib = r_ones;
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_bcd (w_nib),
        .o_seg (w_dec)
    );

    assign w_slot_seg = (r_idx == SLOT_DEG) ? SEG_DEG : w_dec;

`ifdef DISP_LZB_EN
    // Tens is only a leading zero when hundreds is also zero.
    assign w_lzb = ((r_idx == SLOT_HUND) && (r_hund == 4'd0)) ||
                   ((r_idx == SLOT_TENS) && (r_hund == 4'd0) && (r_tens == 4'd0));
`else
    assign w_lzb = 1'b0;
`endif

    assign w_dark = (r_cnt < BLANK_LIM) || w_lzb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= SLOT_ONES;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_slot_end && (r_idx == SLOT_DEG);
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= slot_e'(r_idx + 2'd1);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
            r_hund <= 4'd0;
        end else if (load) begin
            r_ones <= bcd_ones;
            r_tens <= bcd_tens;
            r_hund <= bcd_hund;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else if (w_dark) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_slot_seg;
            r_an  <= ~(4'b0001 << r_idx);
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Self-checking bench for bcd_seg7_scanner (SCAN_DIV=4, BLANK_CYC=1) against a
// cycle-count based display model; follows DISP_LZB_EN when defined.
module tb_bcd_seg7_scanner;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 4 * DIV;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_hund;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    int n_cmp;
    int n_err;

    // Model state: edges since reset release and the shadow digits seen so far.
    int         m_n;
    logic [3:0] m_h, m_t, m_o;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_ft;

    bcd_seg7_scanner #(
        .SCAN_DIV  (DIV),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_ones   (bcd_ones),
        .bcd_tens   (bcd_tens),
        .bcd_hund   (bcd_hund),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Display as seen after edge n: driven from the slot position of edge n-1.
    function automatic void model(input int n, input logic [3:0] h, input logic [3:0] t,
                                  input logic [3:0] o, output logic [3:0] xan,
                                  output logic [6:0] xseg, output logic xft);
        int  p;
        int  s;
        logic blank;
        xft  = (n > 0) && (n % FRAME == 0);
        xan  = 4'b1111;
        xseg = 7'h00;
        if (n == 0) return;
        p = (n - 1) % DIV;
        s = ((n - 1) / DIV) % 4;
        if (p < BLANK) return;
        blank = 1'b0;
`ifdef DISP_LZB_EN
        if (s == 2 && h == 4'd0) blank = 1'b1;
        if (s == 1 && h == 4'd0 && t == 4'd0) blank = 1'b1;
`endif
        if (blank) return;
        case (s)
            0: xseg = dec(o);
            1: xseg = dec(t);
            2: xseg = dec(h);
            default: xseg = 7'h63;
        endcase
        xan[s] = 1'b0;
    endfunction

    task automatic step(input logic ld, input logic [3:0] h, input logic [3:0] t,
                        input logic [3:0] o);
        load     = ld;
        bcd_hund = h;
        bcd_tens = t;
        bcd_ones = o;
        @(posedge clk);
        m_n++;
        model(m_n, m_h, m_t, m_o, e_an, e_seg, e_ft);
        if (ld) begin
            m_h = h;
            m_t = t;
            m_o = o;
        end
        #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_n = 0;
        m_h = 4'd0;
        m_t = 4'd0;
        m_o = 4'd0;
        model(0, m_h, m_t, m_o, e_an, e_seg, e_ft);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (an !== 4'b1111 || seg !== 7'h00 || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: an=%b seg=%h ft=%b exp an=1111 seg=00 ft=0",
                     an, seg, frame_tick);
        end
        step(1'b1, 4'd3, 4'd1, 4'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 4'd0, 4'd0);
        n_cmp++;
        if (an !== e_an || seg !== e_seg) begin
            n_err++;
            $display("FAIL pre_reset_active: an=%b seg=%h exp an=%b seg=%h", an, seg, e_an, e_seg);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (an !== 4'b1111 || seg !== 7'h00 || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: an=%b seg=%h ft=%b exp an=1111 seg=00 ft=0",
                     an, seg, frame_tick);
        end
        do_reset();
    endtask

    task automatic test_scan_315();
        do_reset();
        step(1'b1, 4'd3, 4'd1, 4'd5);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 4'd0, 4'd0, 4'd0);
            n_cmp++;
            if (an !== e_an || seg !== e_seg || frame_tick !== e_ft) begin
                n_err++;
                $display("FAIL scan_315[%0d]: an=%b seg=%h ft=%b exp an=%b seg=%h ft=%b",
                         i, an, seg, frame_tick, e_an, e_seg, e_ft);
            end
        end
    endtask

    task automatic test_frame_tick();
        int pulses;
        int doubles;
        logic prev;
        pulses  = 0;
        doubles = 0;
        prev    = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 4'd0, 4'd0, 4'd0);
            if (frame_tick === 1'b1) pulses++;
            if (frame_tick === 1'b1 && prev === 1'b1) doubles++;
            prev = frame_tick;
            n_cmp++;
            if (frame_tick !== e_ft) begin
                n_err++;
                $display("FAIL frame_tick_phase[%0d]: ft=%b exp %b", i, frame_tick, e_ft);
            end
        end
        n_cmp++;
        if (pulses != 2 || doubles != 0) begin
            n_err++;
            $display("FAIL frame_tick_count: pulses=%0d wide=%0d exp pulses=2 wide=0",
                     pulses, doubles);
        end
    endtask

    task automatic test_pattern(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        step(1'b1, h, t, o);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 4'd0, 4'd0, 4'd0);
            n_cmp++;
            if (an !== e_an || seg !== e_seg || frame_tick !== e_ft) begin
                n_err++;
                $display("FAIL pattern_%h%h%h[%0d]: an=%b seg=%h ft=%b exp an=%b seg=%h ft=%b",
                         h, t, o, i, an, seg, frame_tick, e_an, e_seg, e_ft);
            end
        end
    endtask

    task automatic test_dash();
        test_pattern(4'd3, 4'd1, 4'hA);
    endtask

    task automatic test_lzb();
        test_pattern(4'd0, 4'd4, 4'd5);
        test_pattern(4'd0, 4'd0, 4'd0);
    endtask

    task automatic test_midslot_load();
        do_reset();
        step(1'b1, 4'd3, 4'd1, 4'd5);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 4'd0, 4'd9, 4'd0);
        n_cmp++;
        if (seg !== e_seg || an !== e_an) begin
            n_err++;
            $display("FAIL midslot_first_edge: an=%b seg=%h exp an=%b seg=%h", an, seg, e_an, e_seg);
        end
        step(1'b0, 4'd0, 4'd0, 4'd0);
        n_cmp++;
        if (seg !== 7'h6F || an !== 4'b1101) begin
            n_err++;
            $display("FAIL midslot_second_edge: an=%b seg=%h exp an=1101 seg=6f", an, seg);
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 4'd0, 4'd0, 4'd0);
            n_cmp++;
            if (an !== e_an || seg !== e_seg || frame_tick !== e_ft) begin
                n_err++;
                $display("FAIL midslot_after[%0d]: an=%b seg=%h ft=%b exp an=%b seg=%h ft=%b",
                         i, an, seg, frame_tick, e_an, e_seg, e_ft);
            end
        end
    endtask

    task automatic test_random();
        logic       ld;
        logic [3:0] h, t, o;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            h  = 4'($urandom_range(0, 15));
            t  = 4'($urandom_range(0, 15));
            o  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) h = 4'd0;
            if ($urandom_range(0, 2) == 0) t = 4'd0;
            step(ld, h, t, o);
            n_cmp++;
            if (an !== e_an || seg !== e_seg || frame_tick !== e_ft) begin
                n_err++;
                $display("FAIL random[%0d]: an=%b seg=%h ft=%b exp an=%b seg=%h ft=%b",
                         i, an, seg, frame_tick, e_an, e_seg, e_ft);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_ones = 4'd0;
        bcd_tens = 4'd0;
        bcd_hund = 4'd0;
        m_n      = 0;
        m_h      = 4'd0;
        m_t      = 4'd0;
        m_o      = 4'd0;

        test_reset();
        test_scan_315();
        test_frame_tick();
        test_dash();
        test_lzb();
        test_midslot_load();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
